// File: rtl/sd_block_responder_if.sv
// Core-side SD block handshake plus byte-wide backing-store port for sd_block_responder.
// The responder uses "slave"; the core/memory side uses "master".
interface sd_block_responder_if #(
  parameter int MEM_AW = 21
);
  logic [31:0]       sd_lba;
  logic [1:0]        sd_rd;
  logic [1:0]        sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_wr;
  logic [7:0]        mem_wdata;

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/sd_block_responder.sv
// Serves 512-byte SD block reads/writes for two drives from a byte-wide store.
// sd_ack rises ACK_DELAY+1 cycles after acceptance; 2 cycles per byte; requests are ignored mid-block.
module sd_block_responder #(
  parameter int MEM_AW    = 21,
  parameter int ACK_DELAY = 4
) (
  input logic                 clk_sys,
  input logic                 reset_n,
  sd_block_responder_if.slave bus
);
  localparam int         LBA_W = MEM_AW - 10;
  localparam logic [7:0] DLY   = 8'(ACK_DELAY);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DELAY    = 3'd1;
  localparam logic [2:0] S_RD_FETCH = 3'd2;
  localparam logic [2:0] S_RD_PUT   = 3'd3;
  localparam logic [2:0] S_WR_ADDR  = 3'd4;
  localparam logic [2:0] S_WR_STORE = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [8:0]       off_q, off_d;
  logic             drv_q, drv_d;
  logic             wr_op_q, wr_op_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic             buff_wr, mem_rd, mem_wr;
  logic             unused_lba;

  // Upper LBA bits fall outside the store and are intentionally dropped.
  assign unused_lba = ^bus.sd_lba[31:LBA_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    drv_d   = drv_q;
    wr_op_d = wr_op_q;
    lba_d   = lba_q;
    case (state_q)
      S_IDLE: begin
        if ((|bus.sd_rd) || (|bus.sd_wr)) begin
          state_d = S_DELAY;
          cnt_d   = 8'd0;
          lba_d   = bus.sd_lba[LBA_W-1:0];
          // Drive 0 beats drive 1; within a drive, read beats write.
          if (bus.sd_rd[0]) begin
            drv_d = 1'b0; wr_op_d = 1'b0;
          end else if (bus.sd_wr[0]) begin
            drv_d = 1'b0; wr_op_d = 1'b1;
          end else if (bus.sd_rd[1]) begin
            drv_d = 1'b1; wr_op_d = 1'b0;
          end else begin
            drv_d = 1'b1; wr_op_d = 1'b1;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == DLY) begin
          cnt_d   = 8'd0;
          off_d   = 9'd0;
          state_d = wr_op_q ? S_WR_ADDR : S_RD_FETCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RD_FETCH: state_d = S_RD_PUT;
      S_RD_PUT: begin
        if (off_q == 9'd511) begin
          state_d = S_DONE;
        end else begin
          off_d   = off_q + 9'd1;
          state_d = S_RD_FETCH;
        end
      end
      S_WR_ADDR: state_d = S_WR_STORE;
      S_WR_STORE: begin
        if (off_q == 9'd511) begin
          state_d = S_DONE;
        end else begin
          off_d   = off_q + 9'd1;
          state_d = S_WR_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      off_q   <= 9'd0;
      drv_q   <= 1'b0;
      wr_op_q <= 1'b0;
      lba_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      drv_q   <= drv_d;
      wr_op_q <= wr_op_d;
      lba_q   <= lba_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign buff_wr = (state_q == S_RD_PUT);
  assign mem_rd  = (state_q == S_RD_FETCH);
  assign mem_wr  = (state_q == S_WR_STORE);

  assign bus.sd_ack       = mem_rd || buff_wr || mem_wr || (state_q == S_WR_ADDR);
  assign bus.sd_buff_addr = off_q;
  assign bus.sd_buff_wr   = buff_wr;
  assign bus.sd_buff_dout = buff_wr ? bus.mem_rdata : 8'h00;
  assign bus.mem_rd       = mem_rd;
  assign bus.mem_wr       = mem_wr;
  assign bus.mem_wdata    = mem_wr ? bus.sd_buff_din : 8'h00;
  assign bus.mem_addr     = {drv_q, lba_q, off_q};
endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: store/buffer models, strobe logs, immediate-assertion checks.
module tb_sd_block_responder;
  localparam int AW = 21;

  logic clk_sys;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   strobe_bad = 0;

  sd_block_responder_if #(.MEM_AW(AW)) bus ();

  sd_block_responder #(.MEM_AW(AW), .ACK_DELAY(4)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Backing store: unwritten bytes read as addr[7:0]^0x5A; core buffer returns ~addr.
  logic [7:0] wr_mem [int];
  int         mem_a;
  always @(posedge clk_sys) begin
    mem_a = int'(bus.mem_addr);
    if (bus.mem_rd)
      bus.mem_rdata <= wr_mem.exists(mem_a) ? wr_mem[mem_a] : (bus.mem_addr[7:0] ^ 8'h5A);
    if (bus.mem_wr)
      wr_mem[mem_a] = bus.mem_wdata;
    bus.sd_buff_din <= ~bus.sd_buff_addr[7:0];
  end

  logic [16:0]   rd_log  [$];
  logic [AW+7:0] wr_log  [$];
  logic [AW-1:0] mrd_log [$];
  always @(negedge clk_sys) begin
    if (bus.sd_buff_wr) rd_log.push_back({bus.sd_buff_addr, bus.sd_buff_dout});
    if (bus.mem_wr)     wr_log.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.mem_rd)     mrd_log.push_back(bus.mem_addr);
    if ((int'(bus.sd_buff_wr) + int'(bus.mem_rd) + int'(bus.mem_wr) > 1) ||
        (bus.mem_wr && !bus.sd_ack))
      strobe_bad++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input logic lvl, input int bound, output int n);
    n = 0;
    while (bus.sd_ack !== lvl && n < bound) begin
      @(posedge clk_sys); #1;
      n++;
    end
  endtask

  task automatic run_block(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] lba,
                           output int lat, output int wid);
    repeat (2) @(negedge clk_sys);
    bus.sd_rd  = rd;
    bus.sd_wr  = wr;
    bus.sd_lba = lba;
    @(posedge clk_sys); #1;
    wait_ack(1'b1, 50, lat);
    bus.sd_rd = 2'b00;
    bus.sd_wr = 2'b00;
    wait_ack(1'b0, 2000, wid);
  endtask

  function automatic int rd_errs(input int start, input bit inv);
    int         e;
    logic [7:0] k8;
    logic [7:0] exp;
    e = 0;
    for (int j = 0; j < 512; j++) begin
      k8  = 8'(j);
      exp = inv ? ~k8 : (k8 ^ 8'h5A);
      if (start + j >= rd_log.size()) e++;
      else if (rd_log[start+j] !== {9'(j), exp}) e++;
    end
    return e;
  endfunction

  function automatic int wr_errs(input int start, input logic drv, input logic [10:0] lba);
    int         e;
    logic [7:0] k8;
    e = 0;
    for (int j = 0; j < 512; j++) begin
      k8 = 8'(j);
      if (start + j >= wr_log.size()) e++;
      else if (wr_log[start+j] !== {drv, lba, 9'(j), ~k8}) e++;
    end
    return e;
  endfunction

  int lat, wid, r0, w0, m0, n;

  initial begin
    reset_n    = 1'b0;
    bus.sd_rd  = 2'b00;
    bus.sd_wr  = 2'b00;
    bus.sd_lba = 32'd0;
    #2;
    check("rst_ack",      64'(bus.sd_ack),       64'd0);
    check("rst_buff_wr",  64'(bus.sd_buff_wr),   64'd0);
    check("rst_mem_rd",   64'(bus.mem_rd),       64'd0);
    check("rst_mem_wr",   64'(bus.mem_wr),       64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr),     64'd0);
    check("rst_buf_addr", 64'(bus.sd_buff_addr), 64'd0);
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys) reset_n = 1'b1;

    // Drive 0 read, lba 3
    r0 = rd_log.size(); m0 = mrd_log.size();
    run_block(2'b01, 2'b00, 32'd3, lat, wid);
    check("rd_ack_lat",   64'(lat), 64'd5);
    check("rd_ack_width", 64'(wid), 64'd1024);
    check("rd_count",     64'(rd_log.size() - r0), 64'd512);
    check("rd_data_errs", 64'(rd_errs(r0, 1'b0)), 64'd0);
    check("rd_first_maddr", 64'(mrd_log[m0]), 64'h000600);

    // Drive 1 write, lba 7, then read it back
    r0 = rd_log.size(); w0 = wr_log.size();
    run_block(2'b00, 2'b10, 32'd7, lat, wid);
    check("wr_ack_lat",   64'(lat), 64'd5);
    check("wr_ack_width", 64'(wid), 64'd1024);
    check("wr_count",     64'(wr_log.size() - w0), 64'd512);
    check("wr_errs",      64'(wr_errs(w0, 1'b1, 11'd7)), 64'd0);
    check("wr_no_buff_wr", 64'(rd_log.size() - r0), 64'd0);
    r0 = rd_log.size();
    run_block(2'b10, 2'b00, 32'd7, lat, wid);
    check("rb_count",     64'(rd_log.size() - r0), 64'd512);
    check("rb_data_errs", 64'(rd_errs(r0, 1'b1)), 64'd0);

    // Arbitration: drive-0 write beats drive-1 read raised the same cycle
    repeat (2) @(negedge clk_sys);
    r0 = rd_log.size(); w0 = wr_log.size(); m0 = mrd_log.size();
    bus.sd_rd = 2'b10; bus.sd_wr = 2'b01; bus.sd_lba = 32'd5;
    @(posedge clk_sys); #1;
    wait_ack(1'b1, 50, lat);
    bus.sd_wr = 2'b00;
    wait_ack(1'b0, 2000, wid);
    check("arb1_lat",      64'(lat), 64'd5);
    check("arb1_wr_errs",  64'(wr_errs(w0, 1'b0, 11'd5)), 64'd0);
    check("arb1_no_rd",    64'(rd_log.size() - r0), 64'd0);
    wait_ack(1'b1, 50, lat);
    bus.sd_rd = 2'b00;
    wait_ack(1'b0, 2000, wid);
    check("arb2_lat",      64'(lat), 64'd7);
    check("arb2_rd_count", 64'(rd_log.size() - r0), 64'd512);
    check("arb2_maddr",    64'(mrd_log[m0]), 64'h100A00);
    check("arb2_rd_errs",  64'(rd_errs(r0, 1'b0)), 64'd0);

    // Boundary: all-ones LBA truncates into the store, offset stops at 511
    r0 = rd_log.size(); m0 = mrd_log.size();
    run_block(2'b01, 2'b00, 32'hFFFF_FFFF, lat, wid);
    repeat (20) @(posedge clk_sys); #1;
    check("bnd_first_maddr", 64'(mrd_log[m0]), 64'h0FFE00);
    check("bnd_last_maddr",  64'(mrd_log[mrd_log.size()-1]), 64'h0FFFFF);
    check("bnd_rd_count",    64'(rd_log.size() - r0), 64'd512);
    check("bnd_mrd_count",   64'(mrd_log.size() - m0), 64'd512);
    check("bnd_last_addr",   64'(rd_log[rd_log.size()-1][16:8]), 64'h1FF);

    // Reset in the middle of a read at offset 200
    repeat (2) @(negedge clk_sys);
    bus.sd_rd = 2'b01; bus.sd_lba = 32'd3;
    @(posedge clk_sys); #1;
    wait_ack(1'b1, 50, lat);
    bus.sd_rd = 2'b00;
    n = 0;
    while (!(bus.sd_buff_wr && bus.sd_buff_addr == 9'd200) && n < 1000) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("rst_reached_200", 64'(n < 1000), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ack",     64'(bus.sd_ack),       64'd0);
    check("mid_rst_buff_wr", 64'(bus.sd_buff_wr),   64'd0);
    check("mid_rst_bufaddr", 64'(bus.sd_buff_addr), 64'd0);
    check("mid_rst_dout",    64'(bus.sd_buff_dout), 64'd0);
    check("mid_rst_maddr",   64'(bus.mem_addr),     64'd0);
    check("mid_rst_mem_rd",  64'(bus.mem_rd),       64'd0);
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys) reset_n = 1'b1;
    r0 = rd_log.size(); m0 = mrd_log.size();
    repeat (20) @(posedge clk_sys); #1;
    check("post_rst_idle_ack", 64'(bus.sd_ack), 64'd0);
    check("post_rst_no_strb",  64'((rd_log.size() - r0) + (mrd_log.size() - m0)), 64'd0);
    run_block(2'b01, 2'b00, 32'd3, lat, wid);
    check("post_rst_lat",      64'(lat), 64'd5);
    check("post_rst_count",    64'(rd_log.size() - r0), 64'd512);
    check("post_rst_errs",     64'(rd_errs(r0, 1'b0)), 64'd0);

    check("strobe_exclusive", 64'(strobe_bad), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
